// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter merging four requesters onto one FIFO write port; port 0 ignores the three-quarter-full throttle.
// Grant is registered (1-cycle latency); write strobe/data are combinational; fifo_full stalls the current owner without releasing it.
module fifo_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 32,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic               fifo_full,
  input  logic               fifo_tqf,
  output logic [NREQ-1:0]    gnt,
  output logic               fifo_write,
  output logic [DW-1:0]      fifo_in,
  output logic               busy,
  output logic [1:0]         owner
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state;
  logic [3:0]      beat;
  logic [NREQ-1:0] elig;
  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            found;
  logic            xfer;
  logic            last_beat;
  logic            release_own;

  assign elig = req & {{(NREQ-1){~fifo_tqf}}, 1'b1};

  // Search starts just past the current owner, so the owner itself is tried last.
  always_comb begin
    found  = 1'b0;
    winner = owner;
    idx    = owner;
    for (int k = 1; k <= NREQ; k++) begin
      idx = owner + 2'(k);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign xfer        = (state == OWN) && req[owner] && !fifo_full;
  assign last_beat   = (beat == 4'(BURST - 1));
  assign release_own = !req[owner] || (xfer && last_beat) || (fifo_tqf && (owner != 2'd0));

  assign fifo_write = xfer;
  assign fifo_in    = wdata[int'(owner)*DW +: DW];
  assign busy       = (state == OWN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      beat  <= '0;
      owner <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= OWN;
            owner <= winner;
            gnt   <= NREQ'(1) << winner;
            beat  <= '0;
          end
        end
        OWN: begin
          if (release_own) begin
            if (found) begin
              owner <= winner;
              gnt   <= NREQ'(1) << winner;
              beat  <= '0;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end else if (xfer) begin
            beat <= beat + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench: each step pushes the words it expects onto a queue; a negedge monitor pops and compares every FIFO write.
module tb_fifo_write_arbiter;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*DW-1:0] wdata;
  logic            fifo_full;
  logic            fifo_tqf;
  logic [3:0]      gnt;
  logic            fifo_write;
  logic [DW-1:0]   fifo_in;
  logic            busy;
  logic [1:0]      owner;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  fifo_write_arbiter #(.NREQ(4), .DW(DW), .BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .fifo_full(fifo_full), .fifo_tqf(fifo_tqf),
    .gnt(gnt), .fifo_write(fifo_write), .fifo_in(fifo_in),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return wdata[i*DW +: DW];
  endfunction

  task automatic push(input int i, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(word(i));
  endtask

  task automatic set_data(input logic [DW-1:0] base);
    for (int i = 0; i < 4; i++) wdata[i*DW +: DW] = base + DW'(i * 16'h0101);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_arb(input string tag, input logic [3:0] g, input logic b, input logic w);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_write"}, 32'(fifo_write), 32'(w));
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; fifo_full = 1'b0; fifo_tqf = 1'b0;
    repeat (2) cyc();
    chk_arb("reset", 4'b0000, 1'b0, 1'b0);
    chk("reset_owner", 32'(owner), 32'd3);
    rst = 1'b1;
  endtask

  // Every write must match the oldest outstanding expectation.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (fifo_write === 1'b1) begin
        chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("fifo_in", fifo_in, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req = '0; fifo_full = 1'b0; fifo_tqf = 1'b0; wdata = '0;

    // Sole requester: continuous writes across three bursts.
    do_reset();
    set_data(32'h1000_0000);
    push(0, 12);
    req = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk_arb("solo", 4'b0001, 1'b1, 1'b1);
    end
    chk("solo_owner", 32'(owner), 32'd0);
    half();
    req = 4'b0000;
    cyc();
    chk_arb("solo_end", 4'b0000, 1'b0, 1'b0);
    chk("solo_drained", 32'(exp_q.size()), 32'd0);

    // All four requesting: rotation 0,1,2,3,0 with four words each.
    do_reset();
    set_data(32'h2000_0000);
    push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
    req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk_arb("rr", 4'(1 << (((k - 1) / 4) % 4)), 1'b1, 1'b1);
    end
    half();
    req = 4'b0000;
    cyc();
    chk_arb("rr_end", 4'b0000, 1'b0, 1'b0);
    chk("rr_drained", 32'(exp_q.size()), 32'd0);

    // Full stall after two beats of port 1, then the rest of the burst and rotation.
    do_reset();
    set_data(32'h3000_0000);
    push(1, 4); push(2, 2);
    req = 4'b0110;
    cyc(); chk_arb("stall_b1", 4'b0010, 1'b1, 1'b1);
    cyc(); chk_arb("stall_b2", 4'b0010, 1'b1, 1'b1);
    cyc(); fifo_full = 1'b1; #1;
    chk_arb("stall_c1", 4'b0010, 1'b1, 1'b0);
    cyc(); chk_arb("stall_c2", 4'b0010, 1'b1, 1'b0);
    cyc(); chk_arb("stall_c3", 4'b0010, 1'b1, 1'b0);
    cyc(); fifo_full = 1'b0; #1;
    chk_arb("stall_b3", 4'b0010, 1'b1, 1'b1);
    cyc(); chk_arb("stall_b4", 4'b0010, 1'b1, 1'b1);
    cyc(); chk_arb("stall_next", 4'b0100, 1'b1, 1'b1);
    chk("stall_next_owner", 32'(owner), 32'd2);
    cyc(); chk_arb("stall_next2", 4'b0100, 1'b1, 1'b1);
    half();
    req = 4'b0000;
    cyc();
    chk_arb("stall_end", 4'b0000, 1'b0, 1'b0);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Three-quarter-full throttle: only port 0 may win; a throttled owner is released.
    do_reset();
    set_data(32'h4000_0000);
    fifo_tqf = 1'b1;
    req = 4'b1110;
    cyc(); chk_arb("tqf_blocked1", 4'b0000, 1'b0, 1'b0);
    cyc(); chk_arb("tqf_blocked2", 4'b0000, 1'b0, 1'b0);
    push(0, 2);
    req = 4'b1111;
    cyc(); chk_arb("tqf_port0", 4'b0001, 1'b1, 1'b1);
    cyc(); chk_arb("tqf_port0_b2", 4'b0001, 1'b1, 1'b1);
    half();
    req = 4'b1110;
    cyc(); chk_arb("tqf_idle", 4'b0000, 1'b0, 1'b0);
    fifo_tqf = 1'b0;
    req = 4'b0100;
    push(2, 1);
    cyc(); chk_arb("tqf_port2", 4'b0100, 1'b1, 1'b1);
    chk("tqf_port2_owner", 32'(owner), 32'd2);
    half();
    fifo_tqf = 1'b1;
    cyc(); chk_arb("tqf_release", 4'b0000, 1'b0, 1'b0);
    chk("tqf_drained", 32'(exp_q.size()), 32'd0);
    req = 4'b0000;
    fifo_tqf = 1'b0;

    // Owner drops request after one beat: hand-off with no idle cycle.
    do_reset();
    set_data(32'h5000_0000);
    push(1, 1); push(3, 1);
    req = 4'b1010;
    cyc(); chk_arb("drop_p1", 4'b0010, 1'b1, 1'b1);
    half();
    req = 4'b1000;
    cyc(); chk_arb("drop_p3", 4'b1000, 1'b1, 1'b1);
    chk("drop_p3_owner", 32'(owner), 32'd3);
    half();
    req = 4'b0000;
    cyc(); chk_arb("drop_end", 4'b0000, 1'b0, 1'b0);
    chk("drop_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-burst.
    do_reset();
    set_data(32'h6000_0000);
    push(0, 1);
    req = 4'b0001;
    cyc(); chk_arb("arst_grant", 4'b0001, 1'b1, 1'b1);
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk_arb("arst_now", 4'b0000, 1'b0, 1'b0);
    chk("arst_owner", 32'(owner), 32'd3);
    req = 4'b0100;
    cyc(); cyc();
    chk_arb("arst_held", 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    push(2, 1);
    cyc(); chk_arb("arst_regrant", 4'b0100, 1'b1, 1'b1);
    chk("arst_regrant_owner", 32'(owner), 32'd2);
    half();
    req = 4'b0000;
    cyc(); chk_arb("arst_end", 4'b0000, 1'b0, 1'b0);
    chk("arst_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of write requesters; fixed at 4 in this revision.
REQ-002 Parameter: DW, 32, data width of each requester and of the FIFO write port.
REQ-003 Parameter: BURST, 4, maximum words per grant before re-arbitration, range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  4  per-requester write request, level-held while requester has data.
REQ-007 wdata  input  4*DW  requester data; requester i at bits [i*DW +: DW].
REQ-008 fifo_full  input  1  FIFO full flag, current-cycle.
REQ-009 fifo_tqf  input  1  FIFO three-quarter-full flag, current-cycle.
REQ-010 gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-011 fifo_write  output  1  combinational FIFO write strobe.
REQ-012 fifo_in  output  DW  combinational FIFO write data.
REQ-013 busy  output  1  high while a grant is held.
REQ-014 owner  output  2  index of current or most recent grant holder.

Function
REQ-015 FSM SHALL have two states: IDLE (gnt=0) and OWN (gnt one-hot at owner).
REQ-016 Requester i SHALL be eligible when req[i]=1 and (fifo_tqf=0 or i=0); port 0 is the throttle-exempt priority port.
REQ-017 Arbitration SHALL be round-robin: search order owner+1, owner+2, owner+3, owner (mod 4); first eligible wins.
REQ-018 IDLE -> OWN at the edge where any requester is eligible; gnt visible the cycle after req rises (1-cycle grant latency).
REQ-019 Transfer SHALL occur in a cycle iff state=OWN, req[owner]=1 and fifo_full=0; then fifo_write=1 and fifo_in=wdata[owner].
REQ-020 fifo_write SHALL be 0 in every other cycle; fifo_in SHALL equal wdata[owner] at all times.
REQ-021 Beat counter (4 bits) SHALL increment on each transfer and clear on every new grant.
REQ-022 Release condition in OWN: req[owner]=0, or transfer completing beat BURST, or owner ineligible (fifo_tqf=1 and owner!=0).
REQ-023 On release, the next state SHALL be OWN with the new round-robin winner in the same edge (no idle gap), or IDLE if none is eligible.
REQ-024 A sole eligible requester SHALL be re-granted after its burst with no idle cycle.
REQ-025 fifo_full=1 SHALL stall: no transfer, gnt held, beat counter held; it is not a release condition.
REQ-026 Requester sees its word accepted in exactly the cycles where gnt[i]&req[i]&!fifo_full.
REQ-027 busy SHALL equal (state=OWN); owner SHALL update only on a new grant.

Reset
REQ-028 rst=0 SHALL immediately force state=IDLE, gnt=0, beat counter=0, owner=3 (so port 0 wins first arbitration), and thereby fifo_write=0 and busy=0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst; no transfer occurs while rst=0; the first grant after release follows REQ-018.

Verification
REQ-030 Reset, req=0001 held, FIFO empty -> gnt=0001 from cycle 1; fifo_write=1 every cycle thereafter; beat counter wraps 1..4 and re-grants with no gap.
REQ-031 req=1111 held, flags low -> owners 0,1,2,3,0, 4 words each, fifo_write continuously 1, fifo_in tracks wdata[owner].
REQ-032 fifo_full=1 after 2 beats of port 1 for 3 cycles -> fifo_write=0, gnt=0010 held; 2 more beats after full drops, then rotation.
REQ-033 fifo_tqf=1, req=1110 -> gnt=0000, busy=0; raise req[0] -> gnt=0001 next cycle; port 2 owning when tqf rises -> released at the next edge.
REQ-034 Owner 1 drops req after 1 beat with req[3] high -> gnt=1000 at next edge, no idle cycle.
REQ-035 rst low mid-burst -> gnt=0000, fifo_write=0 within the same cycle without a clock edge; after release with req=0100 -> gnt=0100 one cycle later.
